// File: rtl/basys3_input_cond_pkg.sv
// Shared constants and types for the Basys3 input conditioning front end.
package basys3_input_cond_pkg;

  localparam int unsigned CLK_EXT_FREQ_HZ = 100_000_000;
  localparam int unsigned DEBOUNCE_MS     = 10;
  localparam int unsigned BTN_COUNT       = 5;
  localparam int unsigned SW_COUNT        = 16;

  typedef enum logic {StInit, StRun} cond_state_e;

  function automatic int unsigned ms_to_cycles(int unsigned freq_hz, int unsigned ms);
    return (freq_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/IBUF.sv
// Behavioural stand-in for the Xilinx pad input buffer; the vendor primitive replaces it in
// implementation.
module IBUF (
  output logic O,
  input  logic I
);

  assign O = I;

endmodule

// File: rtl/input_debounce_ch.sv
// One input channel: synchroniser, stable-count debouncer and registered edge pulses.
module input_debounce_ch #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + SYNC_STAGES)
) (
  input  logic clk_ext,
  input  logic rst,
  input  logic run,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  logic             sync_out;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, rise_d, fall_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // Before run, the level simply tracks the synchroniser so start-up emits no pulses.
  always_comb begin
    cnt_d   = '0;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!run) begin
      level_d = sync_out;
    end else if (sync_out != level) begin
      if (cnt_q == CntLast) begin
        level_d = sync_out;
        rise_d  = sync_out;
        fall_d  = ~sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      cnt_q <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

endmodule

// File: rtl/basys3_input_cond.sv
// Basys3 button/switch front end: pad buffers, per-channel debouncers and the start-up
// sequencer that preloads debounced levels before edge reporting is enabled.
module basys3_input_cond
  import basys3_input_cond_pkg::*;
#(
  parameter int unsigned NUM_CH          = BTN_COUNT,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLK_EXT_FREQ_HZ, DEBOUNCE_MS)
) (
  input  logic              clk_ext,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_pad,
  output logic [NUM_CH-1:0] in_level,
  output logic [NUM_CH-1:0] in_rise,
  output logic [NUM_CH-1:0] in_fall,
  output logic              any_event,
  output logic              ready
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + SYNC_STAGES);
  localparam logic [CNT_W-1:0] InitLast = CNT_W'(SYNC_STAGES + DEBOUNCE_CYCLES - 1);

  cond_state_e      state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic             ready_d;
  logic             run;
  logic [NUM_CH-1:0] pad_buf;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready;
    unique case (state_q)
      StInit: begin
        if (init_cnt_q == InitLast) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      StRun:   ready_d = 1'b1;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      ready      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready      <= ready_d;
    end
  end

  assign run = (state_q == StRun);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    IBUF u_ibuf (
      .O (pad_buf[i]),
      .I (in_pad[i])
    );

    input_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk_ext (clk_ext),
      .rst     (rst),
      .run     (run),
      .pad     (pad_buf[i]),
      .level   (in_level[i]),
      .rise    (in_rise[i]),
      .fall    (in_fall[i])
    );
  end

  assign any_event = |(in_rise | in_fall);

endmodule

// File: tb/tb_basys3_input_cond.sv
// Scoreboard bench for basys3_input_cond: a window-based reference model predicts every
// visible output change; a monitor compares each observed change against the prediction.
module tb_basys3_input_cond;

  localparam int unsigned NCh  = 4;
  localparam int unsigned Sync = 2;
  localparam int unsigned Deb  = 8;

  typedef struct {
    int unsigned    cyc;
    logic [NCh-1:0] lvl;
    logic [NCh-1:0] rise;
    logic [NCh-1:0] fall;
    logic           rdy;
  } exp_t;

  logic           clk, rst;
  logic [NCh-1:0] in_pad, in_level, in_rise, in_fall;
  logic           any_event, ready;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  exp_t        exp_q[$];

  int unsigned rise_cnt[NCh], fall_cnt[NCh], last_rise[NCh], last_fall[NCh];
  int unsigned ready_rise_cyc = 0;
  int unsigned rel_cyc = 0;

  basys3_input_cond #(
    .NUM_CH          (NCh),
    .SYNC_STAGES     (Sync),
    .DEBOUNCE_CYCLES (Deb)
  ) dut (
    .clk_ext   (clk),
    .rst       (rst),
    .in_pad    (in_pad),
    .in_level  (in_level),
    .in_rise   (in_rise),
    .in_fall   (in_fall),
    .any_event (any_event),
    .ready     (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int unsigned total_pulses();
    int unsigned t = 0;
    for (int c = 0; c < NCh; c++) t += rise_cnt[c] + fall_cnt[c];
    return t;
  endfunction

  // Reference model: the synchronised value seen at an edge is the pad sampled Sync edges
  // earlier; a running channel flips when the last Deb synchronised samples all differ
  // from the current level. Start-up lasts Sync+Deb edges with the level tracking the pads.
  logic [NCh-1:0] samp[$];
  logic [NCh-1:0] used[$];
  logic [NCh-1:0] m_lvl = '0;
  logic           m_rdy = 1'b0;
  bit             m_run = 1'b0;

  task automatic model_edge();
    logic [NCh-1:0] s, nl, r, f;
    logic           nr;
    int             k;
    bit             differ;
    exp_t           e;
    e.cyc = cyc;
    cyc++;
    nl = m_lvl;
    nr = m_rdy;
    r  = '0;
    f  = '0;
    if (rst) begin
      samp.delete();
      used.delete();
      nl    = '0;
      nr    = 1'b0;
      m_run = 1'b0;
    end else begin
      k = used.size();
      s = (samp.size() >= Sync) ? samp[samp.size() - Sync] : '0;
      used.push_back(s);
      samp.push_back(in_pad);
      if (!m_run) begin
        nl = s;
        if (k == int'(Sync + Deb - 1)) begin
          m_run = 1'b1;
          nr    = 1'b1;
        end
      end else begin
        for (int ch = 0; ch < NCh; ch++) begin
          differ = 1'b1;
          for (int j = 0; j < Deb; j++) if (used[k-j][ch] == m_lvl[ch]) differ = 1'b0;
          if (differ) begin
            nl[ch] = ~m_lvl[ch];
            if (nl[ch]) r[ch] = 1'b1;
            else        f[ch] = 1'b1;
          end
        end
      end
    end
    if (nl != m_lvl || nr != m_rdy || r != '0 || f != '0) begin
      e.lvl  = nl;
      e.rise = r;
      e.fall = f;
      e.rdy  = nr;
      exp_q.push_back(e);
    end
    m_lvl = nl;
    m_rdy = nr;
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  initial begin : monitor
    logic [NCh-1:0] prev_lvl;
    logic           prev_rdy;
    exp_t           e;
    int unsigned    now;
    prev_lvl = '0;
    prev_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      now = cyc - 1;
      while (exp_q.size() > 0 && exp_q[0].cyc < now) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event: cycle %0d got no change, expected lvl=%b rise=%b fall=%b rdy=%b",
                 e.cyc, e.lvl, e.rise, e.fall, e.rdy);
      end
      if (in_rise != '0 || in_fall != '0 || any_event || in_level !== prev_lvl ||
          ready !== prev_rdy) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != now) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: cycle %0d got lvl=%b rise=%b fall=%b any=%b rdy=%b, expected no change",
                   now, in_level, in_rise, in_fall, any_event, ready);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({in_level, in_rise, in_fall, any_event, ready} !==
              {e.lvl, e.rise, e.fall, |(e.rise | e.fall), e.rdy}) begin
            errors++;
            $display("FAIL event: cycle %0d got lvl=%b rise=%b fall=%b any=%b rdy=%b, expected lvl=%b rise=%b fall=%b any=%b rdy=%b",
                     now, in_level, in_rise, in_fall, any_event, ready,
                     e.lvl, e.rise, e.fall, |(e.rise | e.fall), e.rdy);
          end
        end
      end
      for (int c = 0; c < NCh; c++) begin
        if (in_rise[c] === 1'b1) begin
          rise_cnt[c]++;
          last_rise[c] = now;
        end
        if (in_fall[c] === 1'b1) begin
          fall_cnt[c]++;
          last_fall[c] = now;
        end
      end
      if (ready === 1'b1 && prev_rdy !== 1'b1) ready_rise_cyc = now;
      prev_lvl = in_level;
      prev_rdy = ready;
    end
  end

  initial begin : stim
    int unsigned hold[NCh];
    int unsigned r0, f0, tog, lat, snap;
    for (int c = 0; c < NCh; c++) begin
      rise_cnt[c]  = 0;
      fall_cnt[c]  = 0;
      last_rise[c] = 0;
      last_fall[c] = 0;
      hold[c]      = 0;
    end
    rst    = 1'b1;
    in_pad = 4'b1010;
    step(3);
    rst     = 1'b0;
    rel_cyc = cyc;
    step(20);
    check("startup_ready", ready, 1);
    check("startup_level", in_level, 4'b1010);
    check("startup_ready_latency", ready_rise_cyc - rel_cyc + 1, 10);
    check("startup_no_pulses", total_pulses(), 0);

    // Clean rise on channel 0.
    in_pad[0] = 1'b1;
    tog = cyc;
    step(15);
    check("ch0_level", in_level[0], 1);
    check("ch0_rise_count", rise_cnt[0], 1);
    check("ch0_latency", last_rise[0] - tog + 1, 10);

    // Channel 1: short pulse is rejected, longer pulse accepted both ways.
    in_pad[1] = 1'b0;
    step(15);
    r0 = rise_cnt[1];
    f0 = fall_cnt[1];
    in_pad[1] = 1'b1;
    step(7);
    in_pad[1] = 1'b0;
    step(15);
    check("ch1_glitch7_level", in_level[1], 0);
    check("ch1_glitch7_pulses", rise_cnt[1] - r0 + fall_cnt[1] - f0, 0);
    in_pad[1] = 1'b1;
    step(9);
    in_pad[1] = 1'b0;
    step(20);
    check("ch1_pulse9_rise", rise_cnt[1] - r0, 1);
    check("ch1_pulse9_fall", fall_cnt[1] - f0, 1);
    check("ch1_pulse_spacing", (last_fall[1] - last_rise[1]) >= Deb, 1);

    // Chatter on channel 2 ending high.
    r0 = rise_cnt[2];
    tog = 0;
    for (int i = 0; i < 50; i++) begin
      if (i % 3 == 0) begin
        in_pad[2] = ~in_pad[2];
        tog = cyc;
      end
      step(1);
    end
    step(15);
    lat = last_rise[2] - tog + 1;
    check("ch2_chatter_rise_count", rise_cnt[2] - r0, 1);
    check("ch2_chatter_latency", (lat >= 9 && lat <= 11), 1);
    check("ch2_level", in_level[2], 1);

    // Simultaneous rise on channel 0 and fall on channel 3.
    in_pad[0] = 1'b0;
    step(15);
    in_pad[0] = 1'b1;
    in_pad[3] = 1'b0;
    step(15);
    check("simul_same_cycle", last_rise[0], last_fall[3]);
    check("simul_level", in_level, 4'b0101);

    // Reset part-way through a debounce on channel 2.
    in_pad[2] = 1'b0;
    step(Sync + 5);
    rst = 1'b1;
    step(1);
    check("reset_level", in_level, 0);
    check("reset_pulses", {in_rise, in_fall, any_event}, 0);
    check("reset_ready", ready, 0);
    snap    = total_pulses();
    rst     = 1'b0;
    rel_cyc = cyc;
    step(20);
    check("rereload_ready", ready, 1);
    check("rereload_level", in_level, 4'b0001);
    check("rereload_no_pulses", total_pulses() - snap, 0);
    check("rereload_ready_latency", ready_rise_cyc - rel_cyc + 1, 10);

    // Random per-channel hold times straddling the debounce length, with one reset.
    for (int t = 0; t < 2000; t++) begin
      if (t == 1000) rst = 1'b1;
      if (t == 1003) rst = 1'b0;
      for (int c = 0; c < NCh; c++) begin
        if (hold[c] == 0) begin
          in_pad[c] = ~in_pad[c];
          hold[c]   = $urandom_range(1, 14);
        end else begin
          hold[c]--;
        end
      end
      step(1);
    end
    step(30);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
